// File: rtl/demux1a4_frame.sv
// 1:4 byte demultiplexer: rebuilds 4-lane frames from a serial slot stream.
// Lanes 0-2 are staged; lane 3 goes straight into the frame load on slot 3.
module demux1a4_frame (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in_demux,
    input  logic       valid_in,
    input  logic       align,
    output logic [7:0] data_out0,
    output logic [7:0] data_out1,
    output logic [7:0] data_out2,
    output logic [7:0] data_out3,
    output logic       validout0,
    output logic       validout1,
    output logic       validout2,
    output logic       validout3,
    output logic       frame_strobe,
    output logic [7:0] frame_count
);

    logic [1:0]      slot;
    logic [1:0]      slot_nxt;
    logic            load;
    logic [2:0][7:0] stg_data;
    logic [2:0]      stg_valid;
    logic [3:0][7:0] out_data;
    logic [3:0]      out_valid;

    always_comb begin
        load     = 1'b0;
        slot_nxt = slot + 2'd1;
        if (align) begin
            slot_nxt = 2'd0;
        end else if (slot == 2'd3) begin
            load = 1'b1;
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            slot         <= 2'd0;
            stg_data     <= '0;
            stg_valid    <= '0;
            out_data     <= '0;
            out_valid    <= '0;
            frame_strobe <= 1'b0;
            frame_count  <= 8'd0;
        end else begin
            slot         <= slot_nxt;
            frame_strobe <= load;
            if (align) begin
                stg_valid <= '0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (slot == 2'(k)) begin
                        stg_valid[k] <= valid_in;
                        if (valid_in) stg_data[k] <= data_in_demux;
                    end
                end
            end
            // Invalid lanes keep the last valid byte they presented.
            if (load) begin
                for (int k = 0; k < 3; k++) begin
                    out_valid[k] <= stg_valid[k];
                    if (stg_valid[k]) out_data[k] <= stg_data[k];
                end
                out_valid[3] <= valid_in;
                if (valid_in) out_data[3] <= data_in_demux;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign data_out0 = out_data[0];
    assign data_out1 = out_data[1];
    assign data_out2 = out_data[2];
    assign data_out3 = out_data[3];
    assign validout0 = out_valid[0];
    assign validout1 = out_valid[1];
    assign validout2 = out_valid[2];
    assign validout3 = out_valid[3];

endmodule

// File: doc/demux1a4_frame.md
DEMUX1A4_FRAME -- requirements
Module: demux1a4_frame

Interface
REQ-001 The block SHALL have port clk_4f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port data_in_demux, input, 8 bits: serial byte stream from the upstream 4:1 mux (its dataout_mux).
REQ-004 The block SHALL have port valid_in, input, 1 bit: qualifies data_in_demux (the upstream validout).
REQ-005 The block SHALL have port align, input, 1 bit: forces slot realignment.
REQ-006 The block SHALL have ports data_out0 .. data_out3, output, 8 bits each: parallel lane bytes.
REQ-007 The block SHALL have ports validout0 .. validout3, output, 1 bit each: per-lane valid for the current frame.
REQ-008 The block SHALL have port frame_strobe, output, 1 bit: one-cycle pulse marking a newly loaded frame.
REQ-009 The block SHALL have port frame_count, output, 8 bits: number of frames loaded since reset.

Function
REQ-010 The block SHALL keep a 2-bit slot counter, 0 after reset, that increments by 1 every clk_4f edge and wraps 3 -> 0.
REQ-011 The byte arriving while the slot counter is k SHALL belong to lane k; byte and valid_in are captured on that edge into staging register k and staging valid k.
REQ-012 Staging valid k SHALL equal valid_in as sampled in slot k; an invalid slot SHALL still update staging valid to 0 while leaving staging data k unchanged.
REQ-013 On the edge where the slot counter is 3, all four lanes SHALL load into the output registers simultaneously: lanes 0-2 from staging, lane 3 directly from data_in_demux and valid_in.
REQ-014 Latency from sample edge to output: lane3 data SHALL be visible after its own sample edge; lane0 after 3 further edges; lane1 after 2; lane2 after 1.
REQ-015 Outputs SHALL hold their values for exactly 4 cycles between frame loads.
REQ-016 A lane whose frame valid is 0 SHALL drive validout = 0, and data_out SHALL hold the last valid byte for that lane.
REQ-017 frame_strobe SHALL be 1 for the single cycle following each frame-load edge and 0 otherwise.
REQ-018 frame_count SHALL increment by 1 on each frame-load edge, wrapping 255 -> 0; it counts frames even when all lane valids are 0.
REQ-019 When align = 1 at an edge, the block SHALL:
- set the slot counter to 0 for the next edge;
- clear all staging valids;
- perform no frame load, even if the slot counter was 3;
- leave outputs and frame_count unchanged.
REQ-020 While align is held high on consecutive edges, the slot counter SHALL remain 0 and no frame SHALL load.
REQ-021 After align deasserts, the first edge SHALL be treated as slot 0.
REQ-022 No combinational path SHALL exist from any input to any output.

Reset
REQ-023 While reset = 1, the block SHALL asynchronously force all of the following to 0:
- slot counter;
- staging data and staging valids;
- data_out0..3 and validout0..3;
- frame_strobe and frame_count.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first edge after deassertion SHALL be slot 0.
REQ-025 After reset deasserts, the first frame load SHALL occur on the 4th rising edge.

Verification
REQ-026 Frame test: release reset, drive valid_in = 1 with bytes 0xA0, 0xA1, 0xA2, 0xA3 on four consecutive edges -> after the 4th edge data_out0..3 = A0..A3, validout0..3 = 1111, frame_strobe = 1 for one cycle, frame_count = 1.
REQ-027 Invalid slot: repeat REQ-026 stimulus, then send B0, B1(valid=0), B2, B3 -> outputs B0, A1, B2, B3 with validout = 1,0,1,1.
REQ-028 Align: send C0, C1, assert align on the next edge, then send D0..D3 -> single frame D0..D3 loaded; no frame containing C0/C1; frame_count increments once.
REQ-029 Reset mid-frame: after 2 bytes, pulse reset asynchronously between edges -> all outputs 0 immediately; next 4 bytes E0..E3 form frame 1.
REQ-030 Wrap: run 256 continuous frames -> frame_count returns to 0; frame_strobe pulses exactly 256 times, each spaced 4 cycles apart.
REQ-031 End-to-end: connect the upstream 4:1 mux output to this block, with the mux clocked at clk_4f -> data_out0..3 reproduce mux inputs data_in0..3_mux at a fixed latency, with matching valids.
